vid_timing_gen: RTL



---
 rtl/vid_timing_pkg.sv | 21 ++
 rtl/vid_axis_cntr.sv | 38 +++
 rtl/vid_timing_gen.sv | 114 +++++++++++
 3 files changed

// File: rtl/vid_timing_pkg.sv
// Shared types and default 720p60 geometry for the video timing generator.
package vid_timing_pkg;

  localparam int PIX_W = 24;

  localparam int DEF_HVALID_W = 1280;
  localparam int DEF_HFP_W    = 110;
  localparam int DEF_HSYNC_W  = 40;
  localparam int DEF_HBP_W    = 220;
  localparam int DEF_VVALID_W = 720;
  localparam int DEF_VFP_W    = 5;
  localparam int DEF_VSYNC_W  = 5;
  localparam int DEF_VBP_W    = 20;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP_PEND
  } vtg_state_e;

endpackage

// File: rtl/vid_axis_cntr.sv
// One timing axis: wrapping counter with VALID/FP/SYNC/BP region decode.
module vid_axis_cntr #(
  parameter int VALID = 1280,
  parameter int FP    = 110,
  parameter int SYNC  = 40,
  parameter int BP    = 220,
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             valid,
  output logic             sync,
  output logic             last
);
  import vid_timing_pkg::*;

  localparam int TOTAL = VALID + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] VALID_C   = CNT_W'(VALID);
  localparam logic [CNT_W-1:0] SYNC_LO_C = CNT_W'(VALID + FP);
  localparam logic [CNT_W-1:0] SYNC_HI_C = CNT_W'(VALID + FP + SYNC);
  localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(TOTAL - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + CNT_W'(1);
    end
  end

  assign valid = (cnt < VALID_C);
  assign sync  = (cnt >= SYNC_LO_C) && (cnt < SYNC_HI_C);
  assign last  = (cnt == LAST_C);

endmodule

// File: rtl/vid_timing_gen.sv
// Video timing generator and pixel pump: counters -> stage-1 regs -> pin regs (2 clocks).
// Stops only at a frame boundary; FIFO misses are replaced by UFLOW_COLOR and flagged.
module vid_timing_gen
  import vid_timing_pkg::*;
#(
  parameter int                SYNC_ACTIVE_HIGH_N_LOW = 0,
  parameter int                HVALID_W    = DEF_HVALID_W,
  parameter int                HFP_W       = DEF_HFP_W,
  parameter int                HSYNC_W     = DEF_HSYNC_W,
  parameter int                HBP_W       = DEF_HBP_W,
  parameter int                VVALID_W    = DEF_VVALID_W,
  parameter int                VFP_W       = DEF_VFP_W,
  parameter int                VSYNC_W     = DEF_VSYNC_W,
  parameter int                VBP_W       = DEF_VBP_W,
  parameter logic [PIX_W-1:0]  UFLOW_COLOR = 24'hFF00FF,
  parameter int                CNT_W       = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             drvr_en,
  input  logic             ff_empty,
  output logic             ff_rd_en,
  input  logic [PIX_W-1:0] ff_rdata,
  output logic             undrflw,
  input  logic             undrflw_clr,
  output logic [15:0]      frame_cnt,
  output logic             busy,
  output logic [PIX_W-1:0] HDMI_TX_D,
  output logic             HDMI_TX_DE,
  output logic             HDMI_TX_HS,
  output logic             HDMI_TX_VS
);

  localparam logic SYNC_POL = (SYNC_ACTIVE_HIGH_N_LOW != 0);

  vtg_state_e       state, state_nxt;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_valid, h_sync, h_last;
  logic             v_valid, v_sync, v_last;
  logic             frame_last, de0, uflow;
  logic             de1, hs1, vs1, rd1;

  assign busy = (state != IDLE);

  vid_axis_cntr #(
    .VALID(HVALID_W), .FP(HFP_W), .SYNC(HSYNC_W), .BP(HBP_W), .CNT_W(CNT_W)
  ) u_h_cntr (
    .clk(clk), .rst(rst), .en(busy), .clr(!busy),
    .cnt(h_cnt), .valid(h_valid), .sync(h_sync), .last(h_last)
  );

  vid_axis_cntr #(
    .VALID(VVALID_W), .FP(VFP_W), .SYNC(VSYNC_W), .BP(VBP_W), .CNT_W(CNT_W)
  ) u_v_cntr (
    .clk(clk), .rst(rst), .en(busy && h_last), .clr(!busy),
    .cnt(v_cnt), .valid(v_valid), .sync(v_sync), .last(v_last)
  );

  assign frame_last = busy && h_last && v_last;
  assign de0        = busy && h_valid && v_valid;
  assign ff_rd_en   = de0 && !ff_empty;
  assign uflow      = de0 && ff_empty;

  // A stop request always runs to the end of the current frame.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (drvr_en) state_nxt = RUN;
      RUN:       if (!drvr_en) state_nxt = frame_last ? IDLE : STOP_PEND;
      STOP_PEND: begin
        if (drvr_en)         state_nxt = RUN;
        else if (frame_last) state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      undrflw   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (uflow)            undrflw <= 1'b1;
      else if (undrflw_clr) undrflw <= 1'b0;
      if (frame_last)       frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Stage 1 lines up with the FIFO's registered read data; stage 2 drives the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      de1        <= 1'b0;
      hs1        <= 1'b0;
      vs1        <= 1'b0;
      rd1        <= 1'b0;
      HDMI_TX_DE <= 1'b0;
      HDMI_TX_D  <= '0;
      HDMI_TX_HS <= !SYNC_POL;
      HDMI_TX_VS <= !SYNC_POL;
    end else begin
      de1        <= de0;
      hs1        <= busy && h_sync;
      vs1        <= busy && v_sync;
      rd1        <= ff_rd_en;
      HDMI_TX_DE <= de1;
      HDMI_TX_D  <= de1 ? (rd1 ? ff_rdata : UFLOW_COLOR) : '0;
      HDMI_TX_HS <= !(hs1 ^ SYNC_POL);
      HDMI_TX_VS <= !(vs1 ^ SYNC_POL);
    end
  end

endmodule
